// File: rtl/onehot_pkg.sv
// rtl/onehot_pkg.sv - shared state encoding and pattern helpers for the one-hot button debouncer
package onehot_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_SETTLE  = ST_SETTLE,
    S_PRESSED = ST_PRESSED
  } state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with asynchronous active-high reset
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/onehot_debouncer.sv
// rtl/onehot_debouncer.sv - debounces four raw buttons into a registered one-hot code for the 4-to-2 encoder
module onehot_debouncer
  import onehot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic       Y0,
  output logic       Y1,
  output logic       Y2,
  output logic       Y3,
  output logic       valid,
  output logic       multi
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       p;
  state_t           state, state_nxt;
  logic [3:0]       cand, cand_nxt;
  logic [3:0]       y, y_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             valid_nxt;
  logic             multi_nxt;

  sync2 #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cand  <= 4'd0;
      y     <= 4'd0;
      cnt   <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      y     <= y_nxt;
      cnt   <= cnt_nxt;
      valid <= valid_nxt;
      multi <= multi_nxt;
    end
  end

  // multi only reflects patterns observed while no press is being held
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    y_nxt     = y;
    cnt_nxt   = cnt;
    valid_nxt = 1'b0;
    multi_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_onehot4(p)) begin
          cand_nxt  = p;
          cnt_nxt   = CNT_ONE;
          state_nxt = S_SETTLE;
        end else begin
          multi_nxt = (popcount4(p) > 3'd1);
        end
      end
      S_SETTLE: begin
        if (p != cand) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
          multi_nxt = (popcount4(p) > 3'd1);
        end else if (cnt == CNT_LAST) begin
          y_nxt     = cand;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_PRESSED;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_PRESSED: begin
        // any non-zero sample, including a second button, restarts the release count
        if (p == 4'd0) begin
          if (cnt == CNT_LAST) begin
            y_nxt     = 4'd0;
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      default: begin
        y_nxt     = 4'd0;
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign Y0 = y[0];
  assign Y1 = y[1];
  assign Y2 = y[2];
  assign Y3 = y[3];

endmodule

// File: tb/tb_onehot_debouncer.sv
// tb/tb_onehot_debouncer.sv - scoreboard bench for onehot_debouncer at DEBOUNCE_CYCLES=4
module tb_onehot_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'd0;
  logic       Y0, Y1, Y2, Y3, valid, multi;
  logic [3:0] y;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  onehot_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .Y0    (Y0),
    .Y1    (Y1),
    .Y2    (Y2),
    .Y3    (Y3),
    .valid (valid),
    .multi (multi)
  );

  assign y = {Y3, Y2, Y1, Y0};

  always #5 clk = ~clk;

  function automatic logic [1:0] enc4(input logic [3:0] v);
    case (v)
      4'b0010: return 2'b01;
      4'b0100: return 2'b10;
      4'b1000: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // scoreboard: every valid pulse must match the next queued press
  always @(negedge clk) begin
    n_checks++;
    if ($countones(y) > 1) begin
      n_fail++;
      $display("FAIL onehot_invariant: got %b required one-hot or zero", y);
    end
    if (valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got valid with Y=%b required no valid", y);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (y !== e) begin
          n_fail++;
          $display("FAIL scoreboard_y: got %b required %b", y, e);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // drive between edges, then sample just after the next rising edge has settled
  task automatic cycle(input logic [3:0] pat);
    btn = pat;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn = 4'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (y !== 4'd0) begin n_fail++; $display("FAIL reset_y: got %b required 0000", y); end
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", valid); end
    n_checks++;
    if (multi !== 1'b0) begin n_fail++; $display("FAIL reset_multi: got %b required 0", multi); end
    rst = 1'b0;
  endtask

  task automatic test_press_accept;
    exp_q.push_back(4'b0001);
    for (int k = 1; k <= 12; k++) begin
      cycle(4'b0001);
      n_checks++;
      if (y !== ((k >= 6) ? 4'b0001 : 4'b0000)) begin
        n_fail++; $display("FAIL press_y edge %0d: got %b", k, y);
      end
      n_checks++;
      if (valid !== (k == 6)) begin
        n_fail++; $display("FAIL press_valid edge %0d: got %b required %b", k, valid, (k == 6));
      end
      if (k == 6) begin
        n_checks++;
        if (enc4(y) !== 2'b00) begin n_fail++; $display("FAIL press_enc: got %b required 00", enc4(y)); end
      end
    end
    for (int k = 1; k <= 8; k++) begin
      cycle(4'b0000);
      n_checks++;
      if (y !== ((k >= 6) ? 4'b0000 : 4'b0001)) begin
        n_fail++; $display("FAIL release_y edge %0d: got %b", k, y);
      end
    end
  endtask

  task automatic test_short_bounce;
    for (int k = 1; k <= 12; k++) begin
      cycle((k <= 2) ? 4'b0100 : 4'b0000);
      n_checks++;
      if (y !== 4'd0 || valid !== 1'b0) begin
        n_fail++; $display("FAIL bounce edge %0d: got Y=%b valid=%b required 0000/0", k, y, valid);
      end
    end
  endtask

  task automatic test_multi;
    for (int k = 1; k <= 10; k++) begin
      cycle(4'b0011);
      n_checks++;
      if (multi !== (k >= 3)) begin
        n_fail++; $display("FAIL multi_set edge %0d: got %b required %b", k, multi, (k >= 3));
      end
      n_checks++;
      if (y !== 4'd0 || valid !== 1'b0) begin
        n_fail++; $display("FAIL multi_out edge %0d: got Y=%b valid=%b", k, y, valid);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      cycle(4'b0000);
      n_checks++;
      if (multi !== (k < 3)) begin
        n_fail++; $display("FAIL multi_clear edge %0d: got %b required %b", k, multi, (k < 3));
      end
    end
  endtask

  task automatic test_hold_second;
    exp_q.push_back(4'b1000);
    for (int k = 1; k <= 6; k++) begin
      cycle(4'b1000);
      n_checks++;
      if (y !== ((k >= 6) ? 4'b1000 : 4'b0000)) begin
        n_fail++; $display("FAIL hold_accept edge %0d: got %b", k, y);
      end
    end
    n_checks++;
    if (enc4(y) !== 2'b11) begin n_fail++; $display("FAIL hold_enc: got %b required 11", enc4(y)); end
    for (int k = 1; k <= 5; k++) begin
      cycle(4'b1001);
      n_checks++;
      if (y !== 4'b1000 || valid !== 1'b0) begin
        n_fail++; $display("FAIL second_button edge %0d: got Y=%b valid=%b required 1000/0", k, y, valid);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      cycle(4'b0000);
      n_checks++;
      if (y !== ((k >= 6) ? 4'b0000 : 4'b1000)) begin
        n_fail++; $display("FAIL hold_release edge %0d: got %b", k, y);
      end
    end
  endtask

  task automatic test_release_rebounce;
    exp_q.push_back(4'b0010);
    for (int k = 1; k <= 6; k++) cycle(4'b0010);
    n_checks++;
    if (y !== 4'b0010) begin n_fail++; $display("FAIL rebounce_accept: got %b required 0010", y); end
    for (int k = 1; k <= 11; k++) begin
      cycle((k == 3) ? 4'b0010 : 4'b0000);
      n_checks++;
      if (y !== ((k >= 9) ? 4'b0000 : 4'b0010)) begin
        n_fail++; $display("FAIL rebounce_release edge %0d: got %b", k, y);
      end
    end
  endtask

  task automatic test_async_reset;
    for (int k = 1; k <= 4; k++) cycle(4'b0100);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (y !== 4'd0 || valid !== 1'b0 || multi !== 1'b0) begin
      n_fail++; $display("FAIL rst_settle: got Y=%b valid=%b multi=%b", y, valid, multi);
    end
    btn = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle(4'b0000);
      n_checks++;
      if (y !== 4'd0 || valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_settle_after edge %0d: got Y=%b valid=%b", k, y, valid);
      end
    end
    exp_q.push_back(4'b0100);
    for (int k = 1; k <= 7; k++) cycle(4'b0100);
    n_checks++;
    if (y !== 4'b0100) begin n_fail++; $display("FAIL rst_pressed_pre: got %b required 0100", y); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (y !== 4'd0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_pressed: got Y=%b valid=%b required 0000/0", y, valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'b0100);
    for (int k = 1; k <= 6; k++) begin
      cycle(4'b0100);
      n_checks++;
      if (y !== ((k >= 6) ? 4'b0100 : 4'b0000) || valid !== (k == 6)) begin
        n_fail++; $display("FAIL rst_repress edge %0d: got Y=%b valid=%b", k, y, valid);
      end
    end
    for (int k = 1; k <= 8; k++) cycle(4'b0000);
    n_checks++;
    if (y !== 4'd0) begin n_fail++; $display("FAIL rst_final_release: got %b required 0000", y); end
  endtask

  initial begin
    test_reset();
    test_press_accept();
    test_short_bounce();
    test_multi();
    test_hold_second();
    test_release_rebounce();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending presses required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
